// File: rtl/segment_scan_controller.sv
// rtl/segment_scan_controller.sv - multiplexed 7-segment scanner with blanking and tear-free frame load
// integer_to_segment: active-low g..a pattern for one hex nibble.

module integer_to_segment (
  input  logic [3:0] value,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = 7'h7F;
    case (value)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end
endmodule

module segment_scan_controller #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_blank,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic [7:0]            seg_data,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic [4*DIGITS-1:0]   pend_data_q, pend_data_d, disp_data_q, disp_data_d;
  logic [DIGITS-1:0]     pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  tick_q, tick_d;
  logic                  slot_wrap, frame_end, transfer;
  logic [3:0]            cur_nibble;
  logic [6:0]            cur_seg_n;

  assign cur_nibble = disp_data_q[{idx_q, 2'b00} +: 4];

  integer_to_segment u_enc (
    .value (cur_nibble),
    .seg_n (cur_seg_n)
  );

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    pend_data_d  = pend_data_q;
    pend_blank_d = pend_blank_q;
    pend_dp_d    = pend_dp_q;
    disp_data_d  = disp_data_q;
    disp_blank_d = disp_blank_q;
    disp_dp_d    = disp_dp_q;

    slot_wrap = en && (presc_q == PRESC_LAST);
    frame_end = slot_wrap && (idx_q == IDX_LAST);
    transfer  = load_valid && !pending_q;

    if (en) begin
      presc_d = slot_wrap ? '0 : presc_q + PW'(1);
      if (slot_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    // Commit only ever sees a frame captured on an earlier edge; a same-edge transfer waits a frame.
    if (frame_end && pending_q) begin
      disp_data_d  = pend_data_q;
      disp_blank_d = pend_blank_q;
      disp_dp_d    = pend_dp_q;
      pending_d    = 1'b0;
    end
    if (transfer) begin
      pend_data_d  = load_data;
      pend_blank_d = load_blank;
      pend_dp_d    = load_dp;
      pending_d    = 1'b1;
    end

    if (!en || (presc_q < BLANK_END) || disp_blank_q[idx_q]) begin
      an_d  = '1;
      seg_d = 8'hFF;
    end else begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = {~disp_dp_q[idx_q], cur_seg_n};
    end
    tick_d = frame_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      pend_data_q  <= '0;
      pend_blank_q <= '1;
      pend_dp_q    <= '0;
      disp_data_q  <= '0;
      disp_blank_q <= '1;
      disp_dp_q    <= '0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
      tick_q       <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      pend_data_q  <= pend_data_d;
      pend_blank_q <= pend_blank_d;
      pend_dp_q    <= pend_dp_d;
      disp_data_q  <= disp_data_d;
      disp_blank_q <= disp_blank_d;
      disp_dp_q    <= disp_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      tick_q       <= tick_d;
    end
  end

  assign load_ready = ~pending_q;
  assign an         = an_q;
  assign seg_data   = seg_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_segment_scan_controller.sv
// tb/tb_segment_scan_controller.sv - self-checking bench for segment_scan_controller
// Reference model tracks a linear scan position per frame plus pending/display frame copies.

module tb_segment_scan_controller;
  localparam int DIGITS = 4, SCAN_DIV = 4, BLANK_CYCLES = 1;
  localparam int FRAME = DIGITS * SCAN_DIV;
  // Lit segments (active-high, g..a) for hex 0..F.
  localparam logic [6:0] LIT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst, en, load_valid, load_ready, frame_tick;
  logic [15:0] load_data;
  logic [3:0]  load_blank, load_dp, an;
  logic [7:0]  seg_data;

  always #5 clk = ~clk;

  segment_scan_controller #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .clk(clk), .rst(rst), .en(en), .load_data(load_data), .load_blank(load_blank),
    .load_dp(load_dp), .load_valid(load_valid), .load_ready(load_ready),
    .seg_data(seg_data), .an(an), .frame_tick(frame_tick)
  );

  int checks = 0, errors = 0;
  int m_pos;
  bit m_pend, m_xfer;
  logic [15:0] m_pd, m_dd;
  logic [3:0]  m_pb, m_pp, m_db, m_dp;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_tick;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_pend = 0; m_xfer = 0;
    m_pd = '0; m_pb = 4'hF; m_pp = '0;
    m_dd = '0; m_db = 4'hF; m_dp = '0;
    e_an = 4'hF; e_seg = 8'hFF; e_tick = 0;
  endtask

  task automatic model_step();
    int slot, phase;
    bit boundary;
    logic [3:0] nib;
    slot  = m_pos / SCAN_DIV;
    phase = m_pos % SCAN_DIV;
    if (!en || phase < BLANK_CYCLES || m_db[slot]) begin
      e_an = 4'hF; e_seg = 8'hFF;
    end else begin
      nib   = m_dd[slot*4 +: 4];
      e_an  = ~(4'b0001 << slot);
      e_seg = {~m_dp[slot], ~LIT[nib]};
    end
    boundary = en && (m_pos == FRAME - 1);
    m_xfer = load_valid && !m_pend;
    if (boundary && m_pend) begin
      m_dd = m_pd; m_db = m_pb; m_dp = m_pp; m_pend = 0;
    end
    if (m_xfer) begin
      m_pd = load_data; m_pb = load_blank; m_pp = load_dp; m_pend = 1;
    end
    if (en) m_pos = (m_pos + 1) % FRAME;
    e_tick = boundary;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("an", an, e_an);
    check("seg", seg_data, e_seg);
    check("frame_tick", frame_tick, e_tick);
    check("load_ready", load_ready, !m_pend);
  endtask

  task automatic offer(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p, input int budget);
    bit ok;
    ok = 0;
    load_data = d; load_blank = b; load_dp = p; load_valid = 1;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (m_xfer) ok = 1;
    end
    load_valid = 0;
    load_data = 16'($urandom);
    check("xfer_within_budget", ok, 1);
  endtask

  initial begin
    int cnt, cnt2;
    bit found;
    rst = 1; en = 0; load_valid = 0; load_data = '0; load_blank = '0; load_dp = '0;
    model_reset();
    #1;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg_data, 8'hFF);
    check("rst_ready", load_ready, 1);
    check("rst_tick", frame_tick, 0);
    @(negedge clk); @(negedge clk);
    rst = 0; en = 1;

    // Scan with the power-on blank mask, then reset mid-slot.
    repeat (6) tick();
    load_valid = 1; load_data = 16'hABCD; load_blank = 4'h0;
    tick();
    load_valid = 0;
    #2; rst = 1; #1;
    check("async_rst_an", an, 4'hF);
    check("async_rst_seg", seg_data, 8'hFF);
    check("async_rst_ready", load_ready, 1);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 0;
    repeat (2 * FRAME) tick();

    // First frame; frame_tick must pulse once every FRAME cycles.
    offer(16'h3210, 4'h0, 4'h0, 4);
    repeat (FRAME) tick();
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (frame_tick) cnt++;
      if (an == 4'b1101 && seg_data == 8'hF9) cnt2++;
    end
    check("tick_per_2frames", 16'(cnt), 2);
    check("digit1_cycles", 16'(cnt2), 6);

    // Decimal point and blank mask.
    offer(16'hFEDC, 4'b1000, 4'b0010, 2 * FRAME);
    repeat (FRAME) tick();
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (an[3] == 1'b0) cnt++;
      if (seg_data == 8'h21) cnt2++;
    end
    check("digit3_never_on", 16'(cnt), 0);
    check("d_with_dp_cycles", 16'(cnt2), 3);

    // Back-to-back frames: the second stalls until the first commits.
    offer(16'h1111, 4'h0, 4'h0, 2 * FRAME);
    check("second_stalls", load_ready, 0);
    offer(16'h5A5A, 4'h0, 4'hF, 2 * FRAME);
    repeat (2 * FRAME) tick();

    // Pause mid-slot.
    found = 0;
    for (int i = 0; i < FRAME && !found; i++) begin
      tick();
      if (m_pos % SCAN_DIV == 2) found = 1;
    end
    check("found_mid_slot", found, 1);
    en = 0;
    repeat (10) tick();
    check("paused_an", an, 4'hF);
    en = 1;
    repeat (2 * FRAME) tick();

    // Offer exactly on the boundary edge.
    found = 0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      tick();
      if (m_pos == FRAME - 1 && !m_pend) found = 1;
    end
    check("found_boundary", found, 1);
    load_data = 16'h9876; load_blank = 4'h0; load_dp = 4'h0; load_valid = 1;
    tick();
    load_valid = 0;
    check("bnd_tick", frame_tick, 1);
    check("bnd_ready", load_ready, 0);
    repeat (2 * FRAME + 2) tick();

    // Random traffic with occasional pauses.
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if (!load_valid || m_xfer) begin
        load_valid = ($urandom_range(0, 2) == 0);
        load_data  = 16'($urandom);
        load_blank = 4'($urandom);
        load_dp    = 4'($urandom);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
